// File: rtl/urt_tx_arb.sv
// urt_tx_arb: round-robin arbiter that sequences NREQ byte requesters onto one urt_tx transmitter
module urt_tx_arb #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 2000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_tx_signal,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_done_valid,
    output logic [IDW-1:0]    o_done_id,
    output logic              o_err,
    input  logic              i_err_clr
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
    state_t          r_state;
    logic [IDW-1:0]  r_ptr, r_gnt, r_done_id, w_win, w_nxt;
    logic [TO_W-1:0] r_wd;
    logic [NREQ-1:0] r_req_ready;
    logic [7:0]      r_tx_data, w_data;
    logic            r_tx_signal, r_busy, r_done_valid, r_err;
    // winner: lowest pending id at or above ptr, else lowest pending id overall (wrap)
    always_comb begin
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (i_req_valid[k]) w_win = IDW'(k);
        for (int k = NREQ - 1; k >= 0; k--)
            if (i_req_valid[k] && k >= int'(r_ptr)) w_win = IDW'(k);
        w_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
    // byte lane of the winning requester
    always_comb begin
        w_data = '0;
        for (int k = 0; k < NREQ; k++)
            if (w_win == IDW'(k)) w_data = i_req_data[8*k +: 8];
    end
    // sequencer: grant, launch, wait for done or watchdog expiry; all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_wd         <= '0;
            r_req_ready  <= '0;
            r_tx_signal  <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_req_ready  <= '0;
            r_tx_signal  <= 1'b0;
            r_done_valid <= 1'b0;
            if (i_err_clr) r_err <= 1'b0;
            case (r_state)
                IDLE: if (i_enable && |i_req_valid) begin
                    r_tx_data   <= w_data;
                    r_gnt       <= w_win;
                    r_ptr       <= w_nxt;
                    r_req_ready <= NREQ'(1) << w_win;
                    r_tx_signal <= 1'b1;
                    r_busy      <= 1'b1;
                    r_state     <= LAUNCH;
                end
                LAUNCH: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: if (i_tx_done) begin
                    r_done_valid <= 1'b1;
                    r_done_id    <= r_gnt;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end else if (r_wd == TO_W'(TIMEOUT - 1)) begin
                    r_err     <= 1'b1;
                    r_done_id <= r_gnt;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_req_ready  = r_req_ready;
    assign o_tx_signal  = r_tx_signal;
    assign o_tx_data    = r_tx_data;
    assign o_busy       = r_busy;
    assign o_done_valid = r_done_valid;
    assign o_done_id    = r_done_id;
    assign o_err        = r_err;
endmodule

// File: tb/tb_urt_tx_arb.sv
// tb_urt_tx_arb: directed bench for the round-robin transmitter arbiter
module tb_urt_tx_arb;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1, tx_done = 1'b0, err_clr = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_signal, busy, done_valid, err;
    logic [7:0]  tx_data;
    logic [1:0]  done_id;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    urt_tx_arb #(.NREQ(4), .IDW(2), .TO_W(16), .TIMEOUT(50)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_req_valid(req_valid),
        .i_req_data(req_data), .o_req_ready(req_ready), .o_tx_signal(tx_signal),
        .o_tx_data(tx_data), .i_tx_done(tx_done), .o_busy(busy), .o_done_valid(done_valid),
        .o_done_id(done_id), .o_err(err), .i_err_clr(err_clr)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if ({req_ready, tx_signal, tx_data, busy, done_valid, done_id, err} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {req_ready, tx_signal, tx_data, busy, done_valid, done_id, err});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single;
        req_data = 32'h00A5_0000;
        req_valid = 4'b0100;
        step();
        n_tests++;
        if (req_ready !== 4'b0100 || tx_signal !== 1'b1 || busy !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_launch: ready=%b sig=%b busy=%b data=%h expected 0100 1 1 a5", req_ready, tx_signal, busy, tx_data);
        end
        req_valid = 4'b0000;
        step();
        n_tests++;
        if (req_ready !== 4'b0000 || tx_signal !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wait: ready=%b sig=%b busy=%b expected 0000 0 1", req_ready, tx_signal, busy);
        end
        repeat (5) step();
        n_tests++;
        if (tx_data !== 8'hA5 || done_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: data=%h dv=%b expected a5 0", tx_data, done_valid);
        end
        pulse_done();
        n_tests++;
        if (done_valid !== 1'b1 || done_id !== 2'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: dv=%b id=%0d busy=%b expected 1 2 0", done_valid, done_id, busy);
        end
        step();
        n_tests++;
        if (done_valid !== 1'b0 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_after: dv=%b data=%h expected 0 a5", done_valid, tx_data);
        end
    endtask

    task automatic test_wrap_skip;
        req_data = 32'h0000_2211;
        req_valid = 4'b0011;
        step();
        n_tests++;
        if (req_ready !== 4'b0001 || tx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL wrap_grant0: ready=%b data=%h expected 0001 11", req_ready, tx_data);
        end
        req_valid = 4'b0010;
        step();
        pulse_done();
        n_tests++;
        if (done_valid !== 1'b1 || done_id !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_done0: dv=%b id=%0d expected 1 0", done_valid, done_id);
        end
        step();
        n_tests++;
        if (req_ready !== 4'b0010 || tx_signal !== 1'b1 || tx_data !== 8'h22) begin
            n_fail++;
            $display("FAIL wrap_grant1: ready=%b sig=%b data=%h expected 0010 1 22", req_ready, tx_signal, tx_data);
        end
        req_valid = 4'b0000;
        step();
        pulse_done();
        n_tests++;
        if (done_valid !== 1'b1 || done_id !== 2'd1) begin
            n_fail++;
            $display("FAIL wrap_done1: dv=%b id=%0d expected 1 1", done_valid, done_id);
        end
        step();
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        logic [7:0] eb;
        int w;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_data = 32'h4433_2211;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            e = 2'(i % 4);
            eb = 8'(8'h11 * (i % 4 + 1));
            w = 0;
            do begin
                step();
                w++;
            end while (tx_signal !== 1'b1 && w < 4);
            n_tests++;
            if (tx_signal !== 1'b1 || w != 1 || req_ready !== (4'b0001 << e) || tx_data !== eb) begin
                n_fail++;
                $display("FAIL rr_grant%0d: sig=%b after %0d cycles ready=%b data=%h expected 1 after 1 ready=%b data=%h", i, tx_signal, w, req_ready, tx_data, 4'b0001 << e, eb);
            end
            repeat (3) step();
            pulse_done();
            n_tests++;
            if (done_valid !== 1'b1 || done_id !== e) begin
                n_fail++;
                $display("FAIL rr_done%0d: dv=%b id=%0d expected 1 %0d", i, done_valid, done_id, e);
            end
            if (i == 4) req_valid = 4'b0000;
        end
        step();
    endtask

    task automatic test_watchdog;
        logic bad;
        req_data = 32'h0000_5A00;
        req_valid = 4'b0010;
        step();
        n_tests++;
        if (tx_signal !== 1'b1 || req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL wd_launch: sig=%b ready=%b expected 1 0010", tx_signal, req_ready);
        end
        req_valid = 4'b0000;
        bad = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (err !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_early: got early err/done or busy drop, expected err=0 busy=1 for 50 cycles");
        end
        step();
        n_tests++;
        if (err !== 1'b1 || done_id !== 2'd1 || done_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_timeout: err=%b id=%0d dv=%b busy=%b expected 1 1 0 0", err, done_id, done_valid, busy);
        end
        pulse_done();
        bad = done_valid;
        step();
        bad = bad | done_valid | busy;
        n_tests++;
        if (bad !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_stray: stray=%b err=%b expected 0 1", bad, err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear: err=%b expected 0", err);
        end
    endtask

    task automatic test_done_at_timeout;
        req_data = 32'h00C3_0000;
        req_valid = 4'b0100;
        step();
        n_tests++;
        if (tx_signal !== 1'b1 || req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL edge_launch: sig=%b ready=%b expected 1 0100", tx_signal, req_ready);
        end
        req_valid = 4'b0000;
        repeat (50) step();
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_pre: err=%b busy=%b expected 0 1", err, busy);
        end
        pulse_done();
        n_tests++;
        if (done_valid !== 1'b1 || err !== 1'b0 || done_id !== 2'd2) begin
            n_fail++;
            $display("FAIL edge_done_wins: dv=%b err=%b id=%0d expected 1 0 2", done_valid, err, done_id);
        end
        step();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_err_after: err=%b expected 0", err);
        end
    endtask

    task automatic test_enable;
        logic bad;
        enable = 1'b0;
        req_data = 32'h7E00_0000;
        req_valid = 4'b1000;
        bad = 1'b0;
        repeat (3) begin
            step();
            if (tx_signal !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_block: grant seen while disabled, expected none");
        end
        enable = 1'b1;
        step();
        n_tests++;
        if (req_ready !== 4'b1000 || tx_signal !== 1'b1 || tx_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL enable_grant: ready=%b sig=%b data=%h expected 1000 1 7e", req_ready, tx_signal, tx_data);
        end
        req_valid = 4'b0000;
        step();
        enable = 1'b0;
        step();
        pulse_done();
        enable = 1'b1;
        n_tests++;
        if (done_valid !== 1'b1 || done_id !== 2'd3) begin
            n_fail++;
            $display("FAIL enable_inflight: dv=%b id=%0d expected 1 3", done_valid, done_id);
        end
        step();
    endtask

    task automatic test_reset_mid_wait;
        req_data = 32'hDD00_55CC;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1001;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, tx_signal, tx_data, busy, done_valid, done_id, err} !== 18'h0) begin
            n_fail++;
            $display("FAIL rst_async: got %h expected 0", {req_ready, tx_signal, tx_data, busy, done_valid, done_id, err});
        end
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (req_ready !== 4'b0001 || tx_data !== 8'hCC) begin
            n_fail++;
            $display("FAIL rst_ptr0: ready=%b data=%h expected 0001 cc", req_ready, tx_data);
        end
        req_valid = 4'b1000;
        step();
        pulse_done();
        n_tests++;
        if (done_valid !== 1'b1 || done_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_done0: dv=%b id=%0d expected 1 0", done_valid, done_id);
        end
        step();
        n_tests++;
        if (req_ready !== 4'b1000 || tx_data !== 8'hDD) begin
            n_fail++;
            $display("FAIL rst_pending3: ready=%b data=%h expected 1000 dd", req_ready, tx_data);
        end
        req_valid = 4'b0000;
        step();
        pulse_done();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_skip();
        test_round_robin();
        test_watchdog();
        test_done_at_timeout();
        test_enable();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/urt_tx_arb.md
# urt_tx_arb

Round-robin arbiter and sequencer that shares one `urt_tx` serial transmitter among `NREQ` byte requesters. It accepts one byte per grant and pulses the transmitter's start input. It holds the byte stable for the whole frame, waits for the transmitter's done pulse, then reports completion with the requester id. A watchdog aborts a frame whose done pulse never arrives and raises a sticky error.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: id width, equal to ceil(log2(NREQ)).
- `TO_W`, 16: watchdog counter width.
- `TIMEOUT`, 2000: cycles allowed in WAIT before abort; must exceed 12×bitsPerClk of the attached transmitter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new grants are issued; an in-flight frame completes.
- `req_valid`  in  NREQ  bit i is high while requester i has a byte pending.
- `req_data`  in  8×NREQ  byte of requester i on `[8i+7:8i]`; held until its `req_ready` pulse.
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse.
- `tx_signal`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte to the transmitter; stable from launch until the frame ends.
- `tx_done`  in  1  transmitter done pulse (`sed`).
- `busy`  out  1  high in LAUNCH and WAIT.
- `done_valid`  out  1  one-cycle frame-complete pulse.
- `done_id`  out  IDW  requester id; valid with `done_valid` or `err`.
- `err`  out  1  sticky watchdog error flag.
- `err_clr`  in  1  synchronous clear of `err`.

## Operation
- States: IDLE, LAUNCH, WAIT. All outputs are registered.
- **IDLE**
  - If `enable` and `|req_valid`, select winner g: the first set bit of `req_valid`, searching upward from `ptr` with wrap modulo NREQ.
  - On that edge: capture `req_data[g]` into `tx_data`, store g, set `ptr <= (g+1) mod NREQ`, go to LAUNCH.
- **LAUNCH** (one cycle)
  - `req_ready[g]=1`, `tx_signal=1`, `busy=1`.
  - Clear watchdog count; go to WAIT.
- **WAIT**
  - Increment the watchdog each cycle.
  - `tx_done=1`: next cycle `done_valid=1`, `done_id=g`, go to IDLE.
  - Count reaches `TIMEOUT-1` with no `tx_done`: next cycle `err=1` (sticky), `done_id=g`, no `done_valid`, go to IDLE.
  - `tx_done` on the same cycle as the timeout: done wins, `err` is not set.
- `tx_data` holds its value through IDLE after a frame; it changes only on a new capture.
- `tx_done` outside WAIT is ignored.
- A requester that drops `req_valid` before its grant is simply skipped; there is no penalty.
- `enable` low in IDLE keeps the block in IDLE. `enable` has no effect in LAUNCH or WAIT.
- `err_clr` clears `err` next cycle. If `err_clr` and a new timeout occur on the same cycle, the timeout wins and `err` stays 1.
- Reset (any state, asynchronous)
  - State IDLE, `ptr=0`, stored g=0, watchdog=0.
  - Outputs: `req_ready=0`, `tx_signal=0`, `tx_data=8'h00`, `busy=0`, `done_valid=0`, `done_id=0`, `err=0`.
  - A frame in flight at reset is abandoned; no `done_valid` is issued.

## Timing
- Request seen in IDLE at cycle N: `req_ready` and `tx_signal` at N+1; WAIT from N+2.
- `tx_done` at cycle M: `done_valid` at M+1, IDLE at M+1.
- Earliest next `tx_signal` is M+2. This guarantees the transmitter has returned to its idle state before the next start pulse.
- Back-to-back throughput: one frame per (transmitter frame time + 3) cycles.
- The transmitter samples `tx_data` after its start pulse, so the byte must be stable across the whole frame. The block guarantees this by changing `tx_data` only in IDLE.

## Test plan
- Single request: `req_valid=4'b0100`, byte 8'hA5 -> `req_ready=4'b0100` and `tx_signal` pulse one cycle after; `tx_data=8'hA5` held until `tx_done`; `done_valid` with `done_id=2` one cycle after `tx_done`.
- Round-robin fairness: all four requesters valid continuously from reset -> grant order 0,1,2,3,0; each grant after the first waits for the previous `done_valid`; `tx_signal` pulses are spaced 2 cycles after each `tx_done`.
- Wrap and skip: `ptr=3` after a grant to 2, `req_valid=4'b0011` -> grant 0, then 1.
- Watchdog with `TIMEOUT=50`: `tx_done` never asserted -> `err=1` and `done_id=g` on the 51st cycle after LAUNCH, no `done_valid`; `err_clr` pulse -> `err=0`; a stray later `tx_done` is ignored.
- Boundary events:
  - `tx_done` on the exact timeout cycle -> `done_valid=1`, `err=0`.
  - `enable=0` with requests pending -> no grant; `enable` rising -> grant next cycle.
- Reset mid-WAIT: drop `rst` -> all outputs 0 immediately; after release, the pending `req_valid=4'b1000` is granted with `ptr` restarted at 0 (requester 0 first if also valid).
